// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, ALU flag indices and sequencer states shared by alu_seq16 and its ALU.
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  typedef enum logic [2:0] {IDLE, LO, HI, FIX, WB, DONE} seq_state_t;
endpackage

// File: rtl/alu_seq16.sv
// alu_seq16: runs a 16-bit op as byte passes through an external registered 8-bit ALU.
// Define ALU_SEQ_FASTCARRY_EN to skip the carry-fix pass when the low byte yields no carry.
module alu_seq16 #(
  parameter int W_BYTE = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_op,
  input  logic [2*W_BYTE-1:0]   i_a,
  input  logic [2*W_BYTE-1:0]   i_b,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*W_BYTE-1:0]   o_result,
  output logic [2:0]            o_flags,
  output logic [W_BYTE-1:0]     o_alu_l,
  output logic [W_BYTE-1:0]     o_alu_r,
  output logic [2:0]            o_alu_op,
  input  logic [W_BYTE-1:0]     i_alu,
  input  logic [3:0]            i_alu_flags
);
  import alu_pkg::*;
  localparam int W = 2 * W_BYTE;
  seq_state_t state;
  logic [W-1:0] a, b;
  logic [1:0] op;
  logic [W_BYTE-1:0] lo;
  logic c_lo, c1;
  logic unused_flags;
  assign unused_flags = ^{i_alu_flags[3], i_alu_flags[FLAG_N], i_alu_flags[FLAG_Z]};
  // ALU inputs follow the state directly so FIX can forward the high-byte sum the cycle it appears.
  always_comb begin
    o_alu_l  = state == LO ? a[W_BYTE-1:0] : state == HI ? a[W-1:W_BYTE] : state == FIX ? i_alu : '0;
    o_alu_r  = state == LO ? b[W_BYTE-1:0] : state == HI ? b[W-1:W_BYTE] : state == FIX ? W_BYTE'(c_lo) : '0;
    o_alu_op = (state == LO || state == HI) ? {1'b0, op} : state == FIX ? {1'b0, OP_ADD} : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          a       <= i_a;
          b       <= i_b;
          op      <= i_op;
          o_ready <= 1'b0;
          state   <= LO;
        end
        LO: state <= HI;
        HI: begin
          lo   <= i_alu;
          c_lo <= i_alu_flags[FLAG_C];
          c1   <= 1'b0;
`ifdef ALU_SEQ_FASTCARRY_EN
          state <= (op != OP_ADD || !i_alu_flags[FLAG_C]) ? WB : FIX;
`else
          state <= op != OP_ADD ? WB : FIX;
`endif
        end
        FIX: begin
          c1    <= i_alu_flags[FLAG_C];
          state <= WB;
        end
        WB: begin
          o_result <= {i_alu, lo};
          o_flags  <= {i_alu[W_BYTE-1], op == OP_ADD && (c1 || i_alu_flags[FLAG_C]), {i_alu, lo} == '0};
          o_valid  <= 1'b1;
          state    <= DONE;
        end
        DONE: if (i_ready) begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16: scoreboard bench for alu_seq16 with a behavioural registered 8-bit ALU alongside it.
module tb_alu_seq16;
  logic clk = 0, rst = 1, i_valid = 0, i_ready = 1;
  logic [1:0] i_op = 0;
  logic [15:0] i_a = 0, i_b = 0;
  logic o_ready, o_valid;
  logic [15:0] o_result;
  logic [2:0] o_flags, o_alu_op;
  logic [7:0] o_alu_l, o_alu_r, alu_q = 0;
  logic [3:0] alu_f = 0;
  int cyc = 0, errs = 0, checks = 0;
  typedef struct {logic [15:0] r; logic [2:0] f; int acc; int lat;} exp_t;
  exp_t q[$];
  alu_seq16 dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_flags(o_flags), .o_alu_l(o_alu_l), .o_alu_r(o_alu_r), .o_alu_op(o_alu_op),
    .i_alu(alu_q), .i_alu_flags(alu_f)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Registered ALU; logic ops leave the previous carry in place, as a real ALU's stale flag would.
  always @(posedge clk) begin
    logic [8:0] s;
    logic c;
    c = alu_f[1];
    case (o_alu_op[1:0])
      2'd0: begin s = {1'b0, o_alu_l} + {1'b0, o_alu_r}; c = s[8]; end
      2'd1: s = {1'b0, o_alu_l & o_alu_r};
      2'd2: s = {1'b0, o_alu_l | o_alu_r};
      default: s = {1'b0, o_alu_l ^ o_alu_r};
    endcase
    alu_q <= s[7:0];
    alu_f <= {1'b0, s[7], c, s[7:0] == 8'd0};
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int acc);
    exp_t e;
    int sum;
    logic c;
    sum = int'(a) + int'(b);
    c = op == 2'd0 && sum > 65535;
    e.r = op == 2'd0 ? 16'(sum) : op == 2'd1 ? a & b : op == 2'd2 ? a | b : a ^ b;
    e.f = {e.r[15], c, e.r == 16'd0};
    e.acc = acc;
    e.lat = op == 2'd0 ? 4 : 3;
`ifdef ALU_SEQ_FASTCARRY_EN
    if (op == 2'd0 && int'(a[7:0]) + int'(b[7:0]) < 256) e.lat = 3;
`endif
    return e;
  endfunction
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input bit push);
    int n = 0;
    i_valid = 1; i_op = op; i_a = a; i_b = b;
    while (!o_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_wait", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;
    i_valid = 0; i_op = 2'($urandom); i_a = 16'($urandom); i_b = 16'($urandom);
    if (push) q.push_back(model(op, a, b, cyc));
  endtask
  task automatic cycle1;
    @(posedge clk); #1;
  endtask
  // Monitor: compare each new result against the oldest outstanding expectation.
  initial begin
    logic pv = 0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (o_valid && !pv) begin
        if (q.size() == 0) chk("unexpected_valid", {31'd0, o_valid}, 32'd0);
        else begin
          e = q.pop_front();
          chk("result", {16'd0, o_result}, {16'd0, e.r});
          chk("flags", {29'd0, o_flags}, {29'd0, e.f});
          chk("latency", cyc - e.acc, e.lat);
        end
      end
      pv = o_valid;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) cycle1;
    rst = 0;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_result", {16'd0, o_result}, 32'd0);
    chk("rst_flags", {29'd0, o_flags}, 32'd0);
    issue(2'd0, 16'h00FF, 16'h0001, 1);
    issue(2'd0, 16'hFFFF, 16'h0001, 1);
    issue(2'd0, 16'h8000, 16'h8000, 1);
    issue(2'd1, 16'hF0F0, 16'h0FF0, 1);
    issue(2'd3, 16'h8001, 16'h0001, 1);
    issue(2'd0, 16'h0101, 16'h0202, 1);
    issue(2'd2, 16'h1200, 16'h0034, 1);
    // Backpressure: hold DONE, offer a new request that must be ignored.
    n = 0;
    while (!o_ready && n < 50) begin cycle1; n++; end
    i_ready = 0;
    issue(2'd0, 16'hFFFF, 16'h0001, 1);
    n = 0;
    while (!o_valid && n < 20) begin cycle1; n++; end
    chk("bp_valid", {31'd0, o_valid}, 32'd1);
    i_valid = 1; i_op = 2'd2; i_a = 16'h5555; i_b = 16'h0AAA;
    repeat (5) begin
      cycle1;
      chk("bp_hold_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
      chk("bp_result", {16'd0, o_result}, 32'h0000);
      chk("bp_flags", {29'd0, o_flags}, 32'b011);
    end
    i_valid = 0; i_ready = 1;
    cycle1;
    chk("bp_release_valid", {31'd0, o_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
    // Abort in FIX: two edges after accept the sequencer is in FIX.
    issue(2'd0, 16'h1234, 16'h00FF, 0);
    cycle1;
    cycle1;
    rst = 1;
    cycle1;
    rst = 0;
    chk("abort_valid", {31'd0, o_valid}, 32'd0);
    chk("abort_ready", {31'd0, o_ready}, 32'd1);
    chk("abort_result", {16'd0, o_result}, 32'd0);
    chk("abort_flags", {29'd0, o_flags}, 32'd0);
    chk("abort_alu", {13'd0, o_alu_l, o_alu_r, o_alu_op}, 32'd0);
    issue(2'd0, 16'h7FFF, 16'h0001, 1);
    repeat (40) issue(2'($urandom), 16'($urandom), 16'($urandom), 1);
    n = 0;
    while (q.size() != 0 && n < 50) begin cycle1; n++; end
    chk("drain", q.size(), 0);
    cycle1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq16.md
Name: alu_seq16

Overview:
- Initiator/controller for the 8-bit registered ALU: accepts one 16-bit operation request and drives the ALU operand/op inputs byte by byte.
- Captures the ALU result and flags one cycle after each issue, and propagates the carry between bytes using an extra ALU ADD.
- Returns a 16-bit result plus flags over a valid/ready handshake.
- Sits between the execute stage and the ALU instance.

Parameters:
- W_BYTE, 8, ALU datapath width; result width is 2*W_BYTE.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid & o_ready at rising edge
- i_op  in  2  0 ADD, 1 AND, 2 OR, 3 XOR
- i_a  in  16  left operand
- i_b  in  16  right operand
- o_valid  out  1  result valid
- i_ready  in  1  result consumed when o_valid & i_ready at rising edge
- o_result  out  16  result
- o_flags  out  3  {N,C,Z}: N=o_result[15], C=carry out of bit 15 (ADD only, else 0), Z=(o_result==0)
- o_alu_l  out  8  to ALU left operand
- o_alu_r  out  8  to ALU right operand
- o_alu_op  out  3  to ALU op ({1'b0,op})
- i_alu  in  8  ALU registered result
- i_alu_flags  in  4  ALU flags; bit1 = carry, valid only after an ADD

Behaviour:
- ALU contract: inputs presented during cycle N are latched at the edge ending N; i_alu/i_alu_flags are valid during cycle N+1.
- States: IDLE, LO, HI, FIX, WB, DONE.
- Reset: state=IDLE, o_ready=1, o_valid=0, o_result=0, o_flags=0, o_alu_l/r=0, o_alu_op=0. Reset mid-operation aborts the request; no result is produced.
- IDLE: o_ready=1. On accept, latch a, b and op; go to LO.
- LO: drive a[7:0], b[7:0], op; go to HI.
- HI: capture lo=i_alu and c_lo=i_alu_flags[1]; drive a[15:8], b[15:8], op; go to FIX if ADD, else WB.
- FIX: capture c1=i_alu_flags[1]; drive l=i_alu, r={7'b0,c_lo}, op=ADD; go to WB.
- WB: capture hi=i_alu.
  - ADD: C = c1 | i_alu_flags[1]; c1 and the FIX carry are never both 1.
  - Logic ops: C=0; the ALU's stale carry is ignored.
  - Load o_result and o_flags; go to DONE.
- DONE: o_valid=1; o_result and o_flags held stable. On i_ready, go to IDLE.
  - o_ready=0 in every state other than IDLE; there is no accept in the same cycle as consume.
- Latency from the accept edge to o_valid high: ADD 4 cycles, logic ops 3 cycles.
- Arithmetic is modulo 2^16; no overflow flag.
- o_alu_* are don't-care outside LO/HI/FIX but are driven 0 in IDLE and DONE.
- i_a, i_b, i_op changes after accept are ignored.

Optional Feature:
- ALU_SEQ_FASTCARRY_EN defined: in HI with op=ADD and i_alu_flags[1]==0, skip FIX and go to WB; ADD latency becomes 3 cycles when there is no low-byte carry, else 4.
- Not defined: ADD always passes through FIX (fixed 4-cycle latency).

Decomposition:
- Shared package alu_pkg holds:
  - op encodings OP_ADD=0, OP_AND=1, OP_OR=2, OP_XOR=3;
  - ALU flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2;
  - the sequencer state enum.
- No sub-module. The ALU is instantiated alongside this block by the parent, not inside it.

Test Plan:
- ADD 0x00FF+0x0001, i_ready=1 → o_result=0x0100, flags N=0 C=0 Z=0, o_valid exactly 4 cycles after accept.
- ADD 0xFFFF+0x0001 → 0x0000, C=1, Z=1, N=0; ADD 0x8000+0x8000 → 0x0000, C=1, Z=1.
- AND 0xF0F0&0x0FF0 → 0x00F0, C=0 even after a preceding carry-producing ADD, 3-cycle latency; XOR 0x8001^0x0001 → 0x8000, N=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE → o_result/o_flags stable, o_ready=0, new i_valid ignored; then i_ready=1 → IDLE next cycle.
- Reset asserted in FIX → next cycle IDLE, o_valid=0, all outputs 0; the following request completes normally.
- With ALU_SEQ_FASTCARRY_EN: ADD 0x0101+0x0202 → 0x0303 in 3 cycles; ADD 0x00FF+0x0001 → 0x0100 in 4 cycles.
